// File: rtl/scanner_pkg.sv
// Shared definitions for the laser line scanner datapath.
// Holds the locator FSM state type, the {field, vblank, hblank} bit
// positions of the fvh bus, and the bit that marks a bright pixel.
package scanner_pkg;

    typedef enum logic [1:0] {
        VBLANK = 2'd0,
        HBLANK = 2'd1,
        ACTIVE = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int unsigned FVH_FIELD  = 2;
    localparam int unsigned FVH_V      = 1;
    localparam int unsigned FVH_H      = 0;
    localparam int unsigned BRIGHT_BIT = 7;

endpackage

// File: rtl/run_tracker.sv
// Tracks the currently open bright run and the best (longest) run of a line.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   clear               discard current and best run (applied before pix_en)
//   pix_en, bright, col one qualified pixel: brightness and its column
//   close               close the open run after this cycle's pixel (if any)
//   best_start/best_len winning run so far; ties keep the earlier run
module run_tracker
#(
    parameter int unsigned COL_W = 10
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             pix_en,
    input  logic             bright,
    input  logic             close,
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] best_start,
    output logic [COL_W-1:0] best_len
);

    localparam logic [COL_W-1:0] LEN_MAX = '1;

    logic             open_q;
    logic [COL_W-1:0] cur_start;
    logic [COL_W-1:0] cur_len;

    logic             open_n;
    logic [COL_W-1:0] start_n;
    logic [COL_W-1:0] len_n;
    logic [COL_W-1:0] bstart_n;
    logic [COL_W-1:0] blen_n;
    logic             do_close;

    // Clear first, then fold in the pixel, then apply any close.
    always_comb begin
        open_n   = open_q & ~clear;
        start_n  = clear ? '0 : cur_start;
        len_n    = clear ? '0 : cur_len;
        bstart_n = clear ? '0 : best_start;
        blen_n   = clear ? '0 : best_len;
        do_close = close;

        if (pix_en) begin
            if (bright) begin
                if (!open_n) begin
                    open_n  = 1'b1;
                    start_n = col;
                    len_n   = COL_W'(1);
                end else if (len_n != LEN_MAX) begin
                    len_n = len_n + COL_W'(1);
                end
            end else begin
                do_close = 1'b1;
            end
        end

        // Strict compare so an equal-length later run never displaces the earlier one.
        if (do_close && open_n) begin
            if (len_n > blen_n) begin
                bstart_n = start_n;
                blen_n   = len_n;
            end
            open_n = 1'b0;
            len_n  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            open_q     <= 1'b0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else begin
            open_q     <= open_n;
            cur_start  <= start_n;
            cur_len    <= len_n;
            best_start <= bstart_n;
            best_len   <= blen_n;
        end
    end

endmodule

// File: rtl/laser_line_locator.sv
// Finds the laser stripe (longest bright run) on each active video line of a
// binarized pixel stream and reports its centre column and row.
// Optional macro SUBPIXEL_EN: col_out widens by one bit and carries the
// centre in half-pixel units (2*start + len - 1).
// Ports:
//   clk, reset_n   pixel clock, synchronous active-low reset
//   fvh_in, dv_in  {field, vblank, hblank} and data valid from threshold
//   din            binarized pixel, bright when bit 7 is set
//   line_valid     one-cycle pulse per finished line
//   line_found     a run of at least MIN_RUN pixels was seen
//   row_out        row of the reported line
//   col_out        stripe centre column (0 when not found)
//   run_len        winning run length (0 when not found)
//   field_out      field bit latched at line start
//   frame_done     one-cycle pulse when vblank rises
module laser_line_locator
    import scanner_pkg::*;
#(
    parameter int unsigned COL_W   = 10,
    parameter int unsigned ROW_W   = 9,
    parameter int unsigned MIN_RUN = 2
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       fvh_in,
    input  logic             dv_in,
    input  logic [7:0]       din,
    output logic             line_valid,
    output logic             line_found,
    output logic [ROW_W-1:0] row_out,
`ifdef SUBPIXEL_EN
    output logic [COL_W:0]   col_out,
`else
    output logic [COL_W-1:0] col_out,
`endif
    output logic [COL_W-1:0] run_len,
    output logic             field_out,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] COL_MAX = '1;
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col;
    logic             col_sat;
    logic [ROW_W-1:0] row;
    logic             v_prev;
    logic             vrise_q;

    logic             trk_clear;
    logic             trk_pix;
    logic             trk_close;
    logic [COL_W-1:0] trk_col;
    logic [COL_W-1:0] best_start;
    logic [COL_W-1:0] best_len;

    logic             pix_act_c;
    logic             vrise_c;
    logic             v_now_c;
    logic             found_c;
    logic             unused_din;
`ifdef SUBPIXEL_EN
    logic [COL_W:0]   center_c;
`else
    logic [COL_W-1:0] center_c;
`endif

    assign pix_act_c  = dv_in & ~fvh_in[FVH_V] & ~fvh_in[FVH_H];
    assign vrise_c    = dv_in & fvh_in[FVH_V] & ~v_prev;
    // Vblank level as of this cycle; dv_in=0 cycles carry the last valid value.
    assign v_now_c    = dv_in ? fvh_in[FVH_V] : v_prev;
    assign found_c    = (best_len >= COL_W'(MIN_RUN));
    assign unused_din = ^din;

`ifdef SUBPIXEL_EN
    assign center_c = {best_start, 1'b0} + (COL_W+1)'(best_len) - (COL_W+1)'(1);
`else
    assign center_c = best_start + ((best_len - COL_W'(1)) >> 1);
`endif

    run_tracker #(.COL_W(COL_W)) u_run_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (trk_clear),
        .pix_en     (trk_pix),
        .bright     (din[BRIGHT_BIT]),
        .close      (trk_close),
        .col        (trk_col),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= VBLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and run-tracker controls.
    always_comb begin
        state_nxt = state;
        trk_clear = 1'b0;
        trk_pix   = 1'b0;
        trk_close = 1'b0;
        trk_col   = col;

        case (state)
            VBLANK: begin
                if (dv_in && !fvh_in[FVH_V]) begin
                    state_nxt = HBLANK;
                end
            end
            HBLANK: begin
                trk_clear = 1'b1;
                trk_col   = '0;
                if (dv_in && fvh_in[FVH_V]) begin
                    state_nxt = VBLANK;
                end else if (pix_act_c) begin
                    trk_pix   = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (dv_in && (fvh_in[FVH_H] || fvh_in[FVH_V])) begin
                    trk_close = 1'b1;
                    state_nxt = REPORT;
                end else if (pix_act_c && !col_sat) begin
                    trk_pix   = 1'b1;
                    // The last addressable column ends any open run.
                    trk_close = (col == COL_MAX);
                end
            end
            REPORT: begin
                state_nxt = v_now_c ? VBLANK : HBLANK;
            end
            default: begin
                state_nxt = VBLANK;
            end
        endcase
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col        <= '0;
            col_sat    <= 1'b0;
            row        <= '0;
            v_prev     <= 1'b0;
            vrise_q    <= 1'b0;
            line_valid <= 1'b0;
            line_found <= 1'b0;
            row_out    <= '0;
            col_out    <= '0;
            run_len    <= '0;
            field_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            line_valid <= 1'b0;
            vrise_q    <= vrise_c;
            // Delayed one cycle so it lines up with the line_valid of a closing line.
            frame_done <= vrise_q;
            if (dv_in) begin
                v_prev <= fvh_in[FVH_V];
            end

            case (state)
                VBLANK: begin
                    row <= '0;
                end
                HBLANK: begin
                    col_sat <= 1'b0;
                    if (state_nxt == ACTIVE) begin
                        col       <= COL_W'(1);
                        field_out <= fvh_in[FVH_FIELD];
                    end else begin
                        col <= '0;
                    end
                end
                ACTIVE: begin
                    if (trk_pix) begin
                        if (col == COL_MAX) begin
                            col_sat <= 1'b1;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                REPORT: begin
                    line_valid <= 1'b1;
                    line_found <= found_c;
                    row_out    <= row;
                    col_out    <= found_c ? center_c : '0;
                    run_len    <= found_c ? best_len : '0;
                    if (row != ROW_MAX) begin
                        row <= row + ROW_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_line_locator.sv
// Self-checking bench for laser_line_locator: directed vector table,
// hand-written frame/reset sequences and randomized lines checked against
// a run-finding reference model.
module tb_laser_line_locator;

    localparam int COL_W   = 10;
    localparam int ROW_W   = 9;
    localparam int MIN_RUN = 2;
    localparam int LINE_N  = 640;
`ifdef SUBPIXEL_EN
    localparam int CO_W = COL_W + 1;
`else
    localparam int CO_W = COL_W;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       fvh_in;
    logic             dv_in;
    logic [7:0]       din;
    logic             line_valid;
    logic             line_found;
    logic [ROW_W-1:0] row_out;
    logic [CO_W-1:0]  col_out;
    logic [COL_W-1:0] run_len;
    logic             field_out;
    logic             frame_done;

    laser_line_locator #(.COL_W(COL_W), .ROW_W(ROW_W), .MIN_RUN(MIN_RUN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fvh_in     (fvh_in),
        .dv_in      (dv_in),
        .din        (din),
        .line_valid (line_valid),
        .line_found (line_found),
        .row_out    (row_out),
        .col_out    (col_out),
        .run_len    (run_len),
        .field_out  (field_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int row;
        int found;
        int col;
        int len;
        int field;
        int cyc;
    } rep_t;

    rep_t rep_q[$];
    rep_t mon_r;
    int   fd_cnt = 0;
    int   fd_cyc = 0;

    always @(negedge clk) begin
        if (line_valid === 1'b1) begin
            mon_r.row   = int'(row_out);
            mon_r.found = int'(line_found);
            mon_r.col   = int'(col_out);
            mon_r.len   = int'(run_len);
            mon_r.field = int'(field_out);
            mon_r.cyc   = cyc;
            rep_q.push_back(mon_r);
        end
        if (frame_done === 1'b1) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_row = 0;
    int exp_fd  = 0;
    bit mv_prev = 1'b0;
    int last_lv_cyc = 0;
    bit pix [0:1023];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input bit dv, input bit [2:0] f, input bit b);
        @(negedge clk);
        dv_in  = dv;
        fvh_in = f;
        din    = b ? 8'hFF : 8'h00;
        if (dv) begin
            if (f[1] && !mv_prev) exp_fd++;
            mv_prev = f[1];
        end
    endtask

    task automatic gap();
        @(negedge clk);
        dv_in  = 1'b0;
        fvh_in = 3'($urandom);
        din    = 8'($urandom);
    endtask

    task automatic fill_runs(input int s0, input int l0, input int s1, input int l1);
        for (int c = 0; c < 1024; c++) pix[c] = 1'b0;
        for (int i = 0; i < l0; i++) pix[s0 + i] = 1'b1;
        for (int i = 0; i < l1; i++) pix[s1 + i] = 1'b1;
    endtask

    task automatic do_vblank(input bit field);
        for (int i = 0; i < 6; i++) drive(1'b1, {field, 2'b11}, 1'b0);
        exp_row = 0;
        chk("frame_done count", fd_cnt, exp_fd);
    endtask

    // Leading hblank, n pixels (optional dv gaps), then hblank or vblank rise.
    task automatic send_line(input int n, input bit field, input int gap_pct,
                             input bit end_v, output int h_cyc);
        for (int i = 0; i < 4; i++) drive(1'b1, {field, 2'b01}, 1'b0);
        for (int c = 0; c < n; c++) begin
            while (int'($urandom_range(99)) < gap_pct) gap();
            drive(1'b1, {field, 2'b00}, pix[c]);
        end
        drive(1'b1, {field, end_v, 1'b1}, 1'b0);
        h_cyc = cyc;
        for (int i = 0; i < 5; i++) drive(1'b1, {field, end_v, 1'b1}, 1'b0);
    endtask

    // Longest run by scanning run boundaries; earlier run wins ties.
    function automatic void model_line(input int n, output int found,
                                       output int col, output int len);
        int bs = 0;
        int bl = 0;
        int st = 0;
        for (int c = 0; c < n; c++) begin
            if (pix[c] && (c == 0 || !pix[c-1])) st = c;
            if (pix[c] && (c == n - 1 || !pix[c+1])) begin
                if (c - st + 1 > bl) begin
                    bl = c - st + 1;
                    bs = st;
                end
            end
        end
        found = (bl >= MIN_RUN) ? 1 : 0;
`ifdef SUBPIXEL_EN
        col = found ? (2 * bs + bl - 1) : 0;
`else
        col = found ? (bs + (bl - 1) / 2) : 0;
`endif
        len = found ? bl : 0;
    endfunction

    task automatic check_line(input string tag, input int e_found, input int e_col,
                              input int e_len, input int e_field, input int h_cyc);
        rep_t r;
        chk({tag, "/report_count"}, rep_q.size(), 1);
        if (rep_q.size() > 0) begin
            r = rep_q.pop_front();
            chk({tag, "/row_out"},    r.row,   exp_row);
            chk({tag, "/line_found"}, r.found, e_found);
            chk({tag, "/col_out"},    r.col,   e_col);
            chk({tag, "/run_len"},    r.len,   e_len);
            chk({tag, "/field_out"},  r.field, e_field);
            chk({tag, "/latency"},    r.cyc - h_cyc, 2);
            last_lv_cyc = r.cyc;
        end
        rep_q.delete();
        exp_row++;
    endtask

    typedef struct {
        int s0; int l0; int s1; int l1;
        int field; int nf; int gap;
        int found; int colf; int cols; int len;
    } vec_t;

    vec_t vt[9];

    initial begin
        int h;
        int ef, ec, el;
        int fd_start;
        int n, k, st, ln, gp;
        bit fld;

        vt[0] = '{100, 5,   0, 0, 0, 0,  0, 1, 102,  204, 5};
        vt[1] = '{ 10, 3,  50, 3, 0, 1,  0, 1,  11,   22, 3};
        vt[2] = '{ 10, 2, 200, 7, 0, 0,  0, 1, 203,  406, 7};
        vt[3] = '{300, 1,   0, 0, 0, 0,  0, 0,   0,    0, 0};
        vt[4] = '{636, 4,   0, 0, 0, 0,  0, 1, 637, 1275, 4};
        vt[5] = '{636, 4,   0, 0, 0, 0, 30, 1, 637, 1275, 4};
        vt[6] = '{  0, 1,   5, 2, 1, 1,  0, 1,   5,   11, 2};
        vt[7] = '{  0, 6,  20, 6, 1, 0,  0, 1,   2,    5, 6};
        vt[8] = '{  0, 0,   0, 0, 1, 0,  0, 0,   0,    0, 0};

        reset_n = 1'b0;
        dv_in   = 1'b0;
        fvh_in  = 3'b000;
        din     = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset/line_valid", int'(line_valid), 0);
        chk("reset/line_found", int'(line_found), 0);
        chk("reset/col_out",    int'(col_out),    0);
        chk("reset/run_len",    int'(run_len),    0);
        chk("reset/row_out",    int'(row_out),    0);
        chk("reset/frame_done", int'(frame_done), 0);
        reset_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].nf != 0) do_vblank(vt[i].field[0]);
            fill_runs(vt[i].s0, vt[i].l0, vt[i].s1, vt[i].l1);
            send_line(LINE_N, vt[i].field[0], vt[i].gap, 1'b0, h);
`ifdef SUBPIXEL_EN
            check_line($sformatf("vec%0d", i), vt[i].found, vt[i].cols, vt[i].len, vt[i].field, h);
`else
            check_line($sformatf("vec%0d", i), vt[i].found, vt[i].colf, vt[i].len, vt[i].field, h);
`endif
        end

        // Three lines, the last closed directly by the vblank rise.
        do_vblank(1'b0);
        fd_start = fd_cnt;
        for (int i = 0; i < 3; i++) begin
            fill_runs(40 * i + 30, 3 + i, 0, 0);
            send_line(LINE_N, 1'b0, 0, (i == 2), h);
            model_line(LINE_N, ef, ec, el);
            check_line($sformatf("frame3/line%0d", i), ef, ec, el, 0, h);
        end
        exp_row = 0;
        chk("frame3/frame_done pulses", fd_cnt - fd_start, 1);
        chk("frame3/frame_done vs line_valid cycle", fd_cyc, last_lv_cyc);
        chk("frame3/frame_done total", fd_cnt, exp_fd);
        fill_runs(20, 8, 0, 0);
        send_line(LINE_N, 1'b0, 0, 1'b0, h);
        model_line(LINE_N, ef, ec, el);
        check_line("frame3/restart", ef, ec, el, 0, h);

        // Reset in the middle of a line.
        fill_runs(100, 5, 0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 3'b001, 1'b0);
        for (int c = 0; c < 200; c++) drive(1'b1, 3'b000, pix[c]);
        @(negedge clk);
        reset_n = 1'b0;
        dv_in   = 1'b0;
        @(negedge clk);
        chk("midreset/line_valid", int'(line_valid), 0);
        chk("midreset/line_found", int'(line_found), 0);
        chk("midreset/col_out",    int'(col_out),    0);
        chk("midreset/run_len",    int'(run_len),    0);
        chk("midreset/row_out",    int'(row_out),    0);
        reset_n = 1'b1;
        mv_prev = 1'b0;
        exp_row = 0;
        repeat (4) gap();
        do_vblank(1'b0);
        chk("midreset/no_report", rep_q.size(), 0);
        rep_q.delete();
        fill_runs(50, 9, 0, 0);
        send_line(LINE_N, 1'b0, 0, 1'b0, h);
        model_line(LINE_N, ef, ec, el);
        check_line("midreset/next", ef, ec, el, 0, h);

        // Randomized lines against the reference model.
        fld = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (t % 6 == 0 || $urandom_range(9) == 0) begin
                fld = 1'($urandom);
                do_vblank(fld);
            end
            n = 64 + int'($urandom_range(576));
            for (int c = 0; c < 1024; c++) pix[c] = 1'b0;
            k = int'($urandom_range(4));
            for (int j = 0; j < k; j++) begin
                st = int'($urandom_range(n - 1));
                ln = 1 + int'($urandom_range(11));
                for (int i = 0; i < ln; i++) begin
                    if (st + i < n) pix[st + i] = 1'b1;
                end
            end
            gp = ($urandom_range(1) == 1) ? 20 : 0;
            send_line(n, fld, gp, 1'b0, h);
            model_line(n, ef, ec, el);
            check_line($sformatf("rand%0d", t), ef, ec, el, int'(fld), h);
        end
        do_vblank(fld);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
